// File: rtl/ov7670_gray_capture.sv
// OV7670 capture front end: pairs sensor bytes into pixels, converts them to
// grayscale (RGB565 or YUV422 chosen per frame), decimates, clips to the
// output window and frames the result with start/done pulses and a counter.
//
// Handshake: gray_valid is a one-cycle strobe with no back-pressure; gray,
// gray_h_cnt and gray_v_cnt are meaningful only in the cycle it is high and
// hold their last value otherwise.
module ov7670_gray_capture #(
  parameter int DATA_WIDTH        = 8,
  parameter int CAM_WINDOW_WIDTH  = 640,
  parameter int CAM_WINDOW_HEIGHT = 480,
  parameter int DECIM_LOG2        = 0
) (
  input  logic                                  cam_PCLK,
  input  logic                                  n_rst,
  input  logic                                  mode,
  input  logic                                  cam_VSYNC,
  input  logic                                  cam_HREF,
  input  logic [7:0]                            cam_D,
  output logic [DATA_WIDTH-1:0]                 gray,
  output logic                                  gray_valid,
  output logic [$clog2(CAM_WINDOW_WIDTH):0]     gray_h_cnt,
  output logic [$clog2(CAM_WINDOW_HEIGHT):0]    gray_v_cnt,
  output logic                                  frame_start,
  output logic                                  frame_done,
  output logic [15:0]                           frame_cnt,
  output logic                                  overrun,
  output logic [1:0]                            fsm_state
);

  localparam int HW = $clog2(CAM_WINDOW_WIDTH) + 1;
  localparam int VW = $clog2(CAM_WINDOW_HEIGHT) + 1;
  localparam int RW = 16;
  localparam logic [RW-1:0] DMASK = RW'((1 << DECIM_LOG2) - 1);
  localparam logic [RW-1:0] W_LIM = RW'(CAM_WINDOW_WIDTH);
  localparam logic [RW-1:0] H_LIM = RW'(CAM_WINDOW_HEIGHT);

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_VBLANK = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t          state;
  logic            mode_q;
  logic            phase;
  logic            href_q;
  logic [7:0]      first_q;
  logic [RW-1:0]   raw_x;
  logic [RW-1:0]   raw_y;

  // stage 0: paired pixel, stage 1: products, stage 2: sum/shift
  logic            s0_valid, s0_mode;
  logic [15:0]     s0_pix;
  logic [HW-1:0]   s0_h;
  logic [VW-1:0]   s0_v;
  logic            s1_valid, s1_mode;
  logic [15:0]     s1_pr, s1_pg, s1_pb;
  logic [7:0]      s1_y;
  logic [HW-1:0]   s1_h;
  logic [VW-1:0]   s1_v;
  logic            s2_valid;
  logic [7:0]      s2_y8;
  logic [HW-1:0]   s2_h;
  logic [VW-1:0]   s2_v;

  logic            start_evt;
  logic            pix_done;
  logic            keep;
  logic            clip;
  logic [RW-1:0]   col;
  logic [RW-1:0]   line;
  logic [7:0]      r8, g8, b8;
  logic [15:0]     sum;
  logic [DATA_WIDTH-1:0] gray_next;

  assign fsm_state = state;

  // Pixel-completion, decimation and window decisions for the byte on cam_D.
  always_comb begin
    start_evt = (state == S_VBLANK) && !cam_VSYNC;
    pix_done  = (state == S_ACTIVE) && cam_HREF && phase;
    col       = raw_x >> DECIM_LOG2;
    line      = raw_y >> DECIM_LOG2;
    keep      = pix_done && ((raw_x & DMASK) == '0) && ((raw_y & DMASK) == '0);
    clip      = (col >= W_LIM) || (line >= H_LIM);
  end

  // Bit-replicated RGB565 expansion and the luma sum of the product stage.
  assign r8  = {s0_pix[15:11], s0_pix[15:13]};
  assign g8  = {s0_pix[10:5],  s0_pix[10:9]};
  assign b8  = {s0_pix[4:0],   s0_pix[4:2]};
  assign sum = s1_pr + s1_pg + s1_pb;

  generate
    if (DATA_WIDTH <= 8) begin : g_narrow
      assign gray_next = s2_y8[7 -: DATA_WIDTH];
    end else begin : g_wide
      assign gray_next = {s2_y8, {(DATA_WIDTH-8){1'b0}}};
    end
  endgenerate

  // Frame FSM: wait for a full vertical blank before the first capture.
  always_ff @(posedge cam_PCLK or negedge n_rst) begin
    if (!n_rst) begin
      state       <= S_SYNC;
      mode_q      <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        S_SYNC:   if (cam_VSYNC) state <= S_VBLANK;
        S_VBLANK: if (!cam_VSYNC) begin
          state       <= S_ACTIVE;
          mode_q      <= mode;
          frame_start <= 1'b1;
        end
        S_ACTIVE: if (cam_VSYNC) begin
          state      <= S_VBLANK;
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 16'd1;
        end
        default:  state <= S_SYNC;
      endcase
    end
  end

  // Byte pairing, raw line/column counting and the sticky clip flag.
  always_ff @(posedge cam_PCLK or negedge n_rst) begin
    if (!n_rst) begin
      phase   <= 1'b0;
      href_q  <= 1'b0;
      first_q <= '0;
      raw_x   <= '0;
      raw_y   <= '0;
      overrun <= 1'b0;
    end else if (start_evt) begin
      phase   <= 1'b0;
      href_q  <= 1'b0;
      raw_x   <= '0;
      raw_y   <= '0;
      overrun <= 1'b0;
    end else if (state == S_ACTIVE) begin
      href_q <= cam_HREF;
      if (cam_HREF) begin
        phase <= ~phase;
        if (!phase) first_q <= cam_D;
        else if (raw_x != '1) raw_x <= raw_x + 1'b1;
        if (keep && clip) overrun <= 1'b1;
      end else begin
        // a dangling first byte is discarded with the phase reset
        phase <= 1'b0;
        raw_x <= '0;
        if (href_q && (raw_x != '0) && (raw_y != '1)) raw_y <= raw_y + 1'b1;
      end
    end else begin
      phase  <= 1'b0;
      href_q <= 1'b0;
      raw_x  <= '0;
    end
  end

  // Stage 0: register the accepted pixel with its output coordinates.
  always_ff @(posedge cam_PCLK or negedge n_rst) begin
    if (!n_rst) begin
      s0_valid <= 1'b0;
      s0_mode  <= 1'b0;
      s0_pix   <= '0;
      s0_h     <= '0;
      s0_v     <= '0;
    end else begin
      s0_valid <= keep && !clip;
      if (keep) begin
        s0_pix  <= {first_q, cam_D};
        s0_mode <= mode_q;
        s0_h    <= HW'(col);
        s0_v    <= VW'(line);
      end
    end
  end

  // Stage 1: luma products; the Y byte rides alongside for YUV frames.
  always_ff @(posedge cam_PCLK or negedge n_rst) begin
    if (!n_rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_pr    <= '0;
      s1_pg    <= '0;
      s1_pb    <= '0;
      s1_y     <= '0;
      s1_h     <= '0;
      s1_v     <= '0;
    end else begin
      s1_valid <= s0_valid;
      s1_mode  <= s0_mode;
      s1_pr    <= 16'(r8) * 16'd77;
      s1_pg    <= 16'(g8) * 16'd150;
      s1_pb    <= 16'(b8) * 16'd29;
      s1_y     <= s0_pix[15:8];
      s1_h     <= s0_h;
      s1_v     <= s0_v;
    end
  end

  // Stage 2: sum and scale back to 8 bits, or pass the Y byte.
  always_ff @(posedge cam_PCLK or negedge n_rst) begin
    if (!n_rst) begin
      s2_valid <= 1'b0;
      s2_y8    <= '0;
      s2_h     <= '0;
      s2_v     <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_y8    <= s1_mode ? s1_y : 8'(sum >> 8);
      s2_h     <= s1_h;
      s2_v     <= s1_v;
    end
  end

  // Stage 3: output register, refreshed only with a valid pixel.
  always_ff @(posedge cam_PCLK or negedge n_rst) begin
    if (!n_rst) begin
      gray_valid <= 1'b0;
      gray       <= '0;
      gray_h_cnt <= '0;
      gray_v_cnt <= '0;
    end else begin
      gray_valid <= s2_valid;
      if (s2_valid) begin
        gray       <= gray_next;
        gray_h_cnt <= s2_h;
        gray_v_cnt <= s2_v;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_gray_capture.sv
// Directed bench for ov7670_gray_capture. Two instances share the sensor
// inputs: dut_a (8-bit gray, no decimation, 4-pixel window width) and
// dut_b (4-bit gray, decimation by 2, default window).
module tb_ov7670_gray_capture;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_rst;
  logic       mode;
  logic       vs;
  logic       href;
  logic [7:0] d;

  logic [7:0]  a_gray;  logic a_valid; logic [2:0]  a_h; logic [9:0] a_v;
  logic        a_fs, a_fd, a_ovr; logic [15:0] a_fcnt; logic [1:0] a_st;
  logic [3:0]  b_gray;  logic b_valid; logic [10:0] b_h; logic [9:0] b_v;
  logic        b_fs, b_fd, b_ovr; logic [15:0] b_fcnt; logic [1:0] b_st;

  ov7670_gray_capture #(.DATA_WIDTH(8), .CAM_WINDOW_WIDTH(4),
                        .CAM_WINDOW_HEIGHT(480), .DECIM_LOG2(0)) dut_a (
    .cam_PCLK(clk), .n_rst(n_rst), .mode(mode), .cam_VSYNC(vs),
    .cam_HREF(href), .cam_D(d), .gray(a_gray), .gray_valid(a_valid),
    .gray_h_cnt(a_h), .gray_v_cnt(a_v), .frame_start(a_fs),
    .frame_done(a_fd), .frame_cnt(a_fcnt), .overrun(a_ovr), .fsm_state(a_st));

  ov7670_gray_capture #(.DATA_WIDTH(4), .CAM_WINDOW_WIDTH(640),
                        .CAM_WINDOW_HEIGHT(480), .DECIM_LOG2(1)) dut_b (
    .cam_PCLK(clk), .n_rst(n_rst), .mode(mode), .cam_VSYNC(vs),
    .cam_HREF(href), .cam_D(d), .gray(b_gray), .gray_valid(b_valid),
    .gray_h_cnt(b_h), .gray_v_cnt(b_v), .frame_start(b_fs),
    .frame_done(b_fd), .frame_cnt(b_fcnt), .overrun(b_ovr), .fsm_state(b_st));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;
  int lat_ref = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rec(input logic [7:0] g, input logic [11:0] h,
                                      input logic [11:0] v);
    return {g, h, v};
  endfunction

  // scoreboard: observed strobes and expected queues
  logic [31:0] a_log[$];
  logic [31:0] b_log[$];
  int          a_cyc[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  int a_fs_n = 0, a_fd_n = 0, b_fs_n = 0, b_fd_n = 0;

  always @(negedge clk) begin
    if (a_valid) begin
      a_log.push_back(rec(a_gray, 12'(a_h), 12'(a_v)));
      a_cyc.push_back(cyc);
    end
    if (b_valid) b_log.push_back(rec(8'(b_gray), 12'(b_h), 12'(b_v)));
    if (a_fs) a_fs_n++;
    if (a_fd) a_fd_n++;
    if (b_fs) b_fs_n++;
    if (b_fd) b_fd_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_logs(input string tag, input logic [31:0] obs[$],
                          input logic [31:0] exp[$]);
    chk({tag, "_count"}, obs.size(), exp.size());
    for (int i = 0; i < obs.size() && i < exp.size(); i++)
      chk($sformatf("%s_px%0d", tag, i), obs[i], exp[i]);
  endtask

  task automatic clear_logs();
    a_log.delete(); b_log.delete(); a_cyc.delete();
    exp_a.delete(); exp_b.delete();
    a_fs_n = 0; a_fd_n = 0; b_fs_n = 0; b_fd_n = 0;
  endtask

  // driver tasks
  task automatic put_byte(input logic [7:0] b);
    @(negedge clk); href = 1'b1; d = b; last_cyc = cyc;
  endtask

  task automatic put_pix(input logic [15:0] p);
    put_byte(p[15:8]);
    put_byte(p[7:0]);
  endtask

  task automatic end_line();
    @(negedge clk); href = 1'b0; d = 8'h00;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_line(input logic [15:0] p, input int n);
    for (int i = 0; i < n; i++) put_pix(p);
    end_line();
  endtask

  task automatic frame_begin();
    @(negedge clk); vs = 1'b1;
    repeat (3) @(negedge clk);
    vs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk); vs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    n_rst = 1'b0; mode = 1'b0; vs = 1'b0; href = 1'b0; d = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_gray", a_gray, 0);   chk("rst_valid", a_valid, 0);
    chk("rst_h", a_h, 0);         chk("rst_v", a_v, 0);
    chk("rst_fs", a_fs, 0);       chk("rst_fd", a_fd, 0);
    chk("rst_fcnt", a_fcnt, 0);   chk("rst_ovr", a_ovr, 0);
    chk("rst_state", a_st, 0);    chk("rst_b_gray", b_gray, 0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 1: RGB565 pure red, 4x2
    mode = 1'b0;
    frame_begin();
    put_pix(16'hF800); lat_ref = last_cyc;
    put_pix(16'hF800); put_pix(16'hF800); put_pix(16'hF800);
    end_line();
    send_line(16'hF800, 4);
    frame_end();
    for (int v = 0; v < 2; v++)
      for (int h = 0; h < 4; h++) exp_a.push_back(rec(8'h4C, 12'(h), 12'(v)));
    exp_b.push_back(rec(8'h04, 12'd0, 12'd0));
    exp_b.push_back(rec(8'h04, 12'd1, 12'd0));
    cmp_logs("f1_a", a_log, exp_a);
    cmp_logs("f1_b", b_log, exp_b);
    chk("f1_latency", (a_cyc.size() > 0) ? 32'(a_cyc[0] - lat_ref) : 32'hFFFF_FFFF, 4);
    chk("f1_spacing", (a_cyc.size() > 1) ? 32'(a_cyc[1] - a_cyc[0]) : 32'hFFFF_FFFF, 2);
    chk("f1_fs", a_fs_n, 1);  chk("f1_fd", a_fd_n, 1);
    chk("f1_b_fs", b_fs_n, 1);
    chk("f1_fcnt", a_fcnt, 1); chk("f1_ovr", a_ovr, 0);
    clear_logs();

    // Frame 2: YUV422 8x4 raw, mode flipped mid-frame, A clips columns 4..7
    mode = 1'b1;
    frame_begin();
    send_line(16'hA580, 8);
    mode = 1'b0;
    send_line(16'hA580, 8);
    send_line(16'hA580, 8);
    send_line(16'hA580, 8);
    frame_end();
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < 4; h++) exp_a.push_back(rec(8'hA5, 12'(h), 12'(v)));
    for (int v = 0; v < 2; v++)
      for (int h = 0; h < 4; h++) exp_b.push_back(rec(8'h0A, 12'(h), 12'(v)));
    cmp_logs("f2_a", a_log, exp_a);
    cmp_logs("f2_b", b_log, exp_b);
    chk("f2_a_ovr", a_ovr, 1);
    chk("f2_b_ovr", b_ovr, 0);
    chk("f2_fcnt", a_fcnt, 2);
    clear_logs();

    // Frame 3: RGB colours, odd trailing byte, overrun cleared at start
    chk("f3_ovr_held", a_ovr, 1);
    frame_begin();
    chk("f3_ovr_cleared", a_ovr, 0);
    put_pix(16'h07E0); put_pix(16'hFFFF); put_pix(16'h001F);
    put_byte(8'hF8);
    end_line();
    send_line(16'hF800, 1);
    frame_end();
    exp_a.push_back(rec(8'h95, 12'd0, 12'd0));
    exp_a.push_back(rec(8'hFF, 12'd1, 12'd0));
    exp_a.push_back(rec(8'h1C, 12'd2, 12'd0));
    exp_a.push_back(rec(8'h4C, 12'd0, 12'd1));
    exp_b.push_back(rec(8'h09, 12'd0, 12'd0));
    exp_b.push_back(rec(8'h01, 12'd1, 12'd0));
    cmp_logs("f3_a", a_log, exp_a);
    cmp_logs("f3_b", b_log, exp_b);
    chk("f3_fcnt", a_fcnt, 3);
    clear_logs();

    // Frame 4: reset mid-line, then wait for a full VSYNC pulse
    frame_begin();
    put_pix(16'hF800); put_pix(16'hF800);
    @(negedge clk); n_rst = 1'b0; href = 1'b0;
    repeat (2) @(negedge clk);
    chk("mr_gray", a_gray, 0);   chk("mr_valid", a_valid, 0);
    chk("mr_h", a_h, 0);         chk("mr_v", a_v, 0);
    chk("mr_fcnt", a_fcnt, 0);   chk("mr_ovr", a_ovr, 0);
    chk("mr_state", a_st, 0);    chk("mr_b_fcnt", b_fcnt, 0);
    chk("mr_b_state", b_st, 0);
    n_rst = 1'b1;
    clear_logs();
    send_line(16'hF800, 2);
    repeat (4) @(negedge clk);
    chk("mr_no_px", a_log.size(), 0);
    chk("mr_no_fs", a_fs_n, 0);
    vs = 1'b1;
    repeat (4) @(negedge clk);
    chk("mr_no_fd", a_fd_n, 0);
    mode = 1'b1;
    vs = 1'b0;
    repeat (2) @(negedge clk);
    chk("mr_fs", a_fs_n, 1);
    send_line(16'h5A80, 1);
    frame_end();
    exp_a.push_back(rec(8'h5A, 12'd0, 12'd0));
    exp_b.push_back(rec(8'h05, 12'd0, 12'd0));
    cmp_logs("f4_a", a_log, exp_a);
    cmp_logs("f4_b", b_log, exp_b);
    chk("f4_fd", a_fd_n, 1);
    chk("f4_fcnt", a_fcnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ov7670_gray_capture.md
Name: ov7670_gray_capture

Overview:
Parametrised successor to the camera capture and grayscale path: one block that deserialises OV7670 byte pairs, converts them to grayscale and emits counted, decimated, window-clipped pixels with frame framing. It supports RGB565 or YUV422 input selected at run time and a configurable output width. It runs in the camera pixel-clock domain, between the SCCB-configured sensor and downstream image processing.

Parameters:
DATA_WIDTH, 8, gray output width (4..12).
CAM_WINDOW_WIDTH, 640, max output pixels per line after decimation.
CAM_WINDOW_HEIGHT, 480, max output lines per frame after decimation.
DECIM_LOG2, 0, decimation factor 2^DECIM_LOG2 in both axes (0..2).

Ports:
cam_PCLK  in  1  pixel clock; the only clock.
n_rst  in  1  asynchronous active-low reset.
mode  in  1  0 = RGB565, 1 = YUV422 (Y byte first); sampled at frame start.
cam_VSYNC  in  1  sensor VSYNC, high during vertical blank.
cam_HREF  in  1  sensor HREF, high during active bytes.
cam_D  in  8  sensor data byte.
gray  out  DATA_WIDTH  grayscale pixel.
gray_valid  out  1  one-cycle strobe qualifying gray and the counters.
gray_h_cnt  out  $clog2(CAM_WINDOW_WIDTH)+1  output column of current pixel.
gray_v_cnt  out  $clog2(CAM_WINDOW_HEIGHT)+1  output line of current pixel.
frame_start  out  1  one-cycle pulse on the VSYNC falling edge that starts a captured frame.
frame_done  out  1  one-cycle pulse on the VSYNC rising edge ending a captured frame.
frame_cnt  out  16  completed frames, wraps at 65535 -> 0.
overrun  out  1  sticky: a pixel or line was clipped this frame; cleared at frame_start.

Behaviour:
- Reset: every output is 0, FSM is in S_SYNC, byte phase is 0, all counters are 0. Reset mid-frame discards the partial frame.
- FSM:
  - S_SYNC waits for VSYNC=1 and then goes to S_VBLANK.
  - S_VBLANK waits for VSYNC=0; on that edge it latches mode, pulses frame_start, clears overrun and goes to S_ACTIVE.
  - S_ACTIVE: VSYNC=1 pulses frame_done, increments frame_cnt and goes to S_VBLANK.
  - The first frame after reset is therefore never partial.
- Byte pairing (S_ACTIVE, HREF=1):
  - Phase toggles on each byte. Phase 0 latches the byte; phase 1 completes a pixel {first, second}.
  - HREF=0 forces phase 0, so a trailing odd byte is dropped.
- Raw counters:
  - raw_x counts completed pixels in the line and clears on the HREF falling edge.
  - raw_y increments on each HREF falling edge that had at least one completed pixel; it clears at frame_start.
- Acceptance: a pixel is kept when raw_x[DECIM_LOG2-1:0]==0 and raw_y[DECIM_LOG2-1:0]==0 (always kept when DECIM_LOG2=0).
  - Output column = raw_x>>DECIM_LOG2; output line = raw_y>>DECIM_LOG2.
  - If column >= CAM_WINDOW_WIDTH or line >= CAM_WINDOW_HEIGHT, the pixel is dropped and overrun is set.
- Gray conversion, RGB565:
  - Expand to 8 bits by bit replication: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
  - Y8 = (77*R8 + 150*G8 + 29*B8) >> 8, using a 16-bit unsigned sum that never overflows.
  - Pipeline: stage 1 = products, stage 2 = sum/shift, stage 3 = output register.
- Gray conversion, YUV422: Y8 = first byte. It is delay-matched through the same 3 stages.
- Width rule: for DATA_WIDTH<=8, gray = Y8[7:8-DATA_WIDTH]; for DATA_WIDTH>8, gray = {Y8, zeros}.
- Latency: gray_valid rises exactly 3 cycles after the cam_PCLK edge that samples the second byte, in both modes. Counters travel with the pixel through the pipe. No bubbles are inserted; back-to-back pixels give gray_valid every 2nd cycle.
- Frame boundaries:
  - frame_done is asserted on the VSYNC edge, regardless of pixels still in flight.
  - In-flight pixels still emerge within 3 cycles carrying their old counters.
- Mode changes take effect only at frame_start.

Test Plan:
- RGB565, DECIM_LOG2=0, 4x2 frame, pixel bytes 0xF8,0x00 (pure red) -> 8 gray_valid strobes with gray=0x4C (77*255>>8=76), h 0..3, v 0..1, 3-cycle latency from second byte, frame_start/frame_done once each, frame_cnt=1.
- YUV422, bytes Y=0xA5,U=0x80 repeated, DATA_WIDTH=4 -> gray=0xA each pixel; mode toggled mid-frame has no effect until next frame_start.
- DECIM_LOG2=1, 8x4 raw frame -> exactly 4x2 outputs, h 0..3, v 0..1; raw odd columns/lines never strobe.
- CAM_WINDOW_WIDTH=4, 6-pixel lines -> columns 4,5 dropped, overrun=1 until next frame_start clears it; odd byte at HREF fall is dropped with no strobe.
- n_rst pulsed mid-frame -> all outputs 0; with VSYNC low no frame_start occurs until a full VSYNC high->low pulse; frame_cnt wraps 0xFFFF -> 0x0000 after forced 65536 frames (or a preload in the bench).
